fetch_queue: RTL

Parametrised instruction fetch with a prefetch queue and multiple outstanding AXI read requests. It issues sequential reads ahead of decode. On a redirect (trap or branch) it flushes the queue and discards responses to stale requests. It presents {pc, ir} packets to decode as an AXI4-Stream source. It sits between the instruction cache (axi master side) and the decode stage, replacing the single-request fetch stage.

---
 rtl/fetch_queue_pkg.sv | 20 ++
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch_queue.sv | 152 +++++++++++++++
 3 files changed

// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch path: AXI4 protection encoding
// and the core-wide word / decode-packet types plus fetch defaults.

package axi4;
   // Instruction fetch, secure, unprivileged.
   localparam logic [2:0] AXI4 = 3'b100;
endpackage

package core;
   typedef logic [31:0] word_t;

   typedef struct packed {
      word_t pc;
      word_t ir;
   } id_t;

   localparam word_t CODE_BASE         = 32'h0000_1000;
   localparam int    FETCH_DEPTH       = 4;
   localparam int    FETCH_OUTSTANDING = 2;
endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: synchronous FIFO of {pc, ir} packets with flush.
// DEPTH must be a power of two so the pointers wrap naturally.

module fetch_fifo
   import core::*;
#(
   parameter int DEPTH = FETCH_DEPTH
) (
   input  logic                       aclk,
   input  logic                       areset,
   input  logic                       push,
   input  id_t                        din,
   input  logic                       pop,
   input  logic                       flush,
   output id_t                        dout,
   output logic [$clog2(DEPTH+1)-1:0] count,
   output logic                       empty,
   output logic                       full
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = $clog2(DEPTH+1);

   id_t           mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          wr_en;
   logic          rd_en;

   assign wr_en = push & ~full;
   assign rd_en = pop & ~empty;
   assign empty = (count == '0);
   assign full  = (count == CW'(DEPTH));
   assign dout  = mem[rd_ptr];

   // Storage array; contents need no reset since count gates visibility.
   always_ff @(posedge aclk) begin
      if (wr_en) mem[wr_ptr] <= din;
   end

   // Pointers and occupancy; flush empties the queue in one cycle.
   always_ff @(posedge aclk) begin
      if (areset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         wr_ptr <= wr_ptr + AW'(wr_en);
         rd_ptr <= rd_ptr + AW'(rd_en);
         count  <= count + CW'(wr_en) - CW'(rd_en);
      end
   end

endmodule

// File: rtl/fetch_queue.sv
// Instruction fetch with prefetch queue and multiple outstanding AXI reads.
// Issues sequential reads ahead of decode, flushes on trap/branch and drops
// responses that belong to the abandoned path.
// Optional macro FETCH_QUEUE_BYPASS_EN: forward an R beat straight to the
// sink when the queue is empty, skipping the one-cycle queue latency.

module fetch_queue
   import core::*, axi4::*;
#(
   parameter int DEPTH           = FETCH_DEPTH,
   parameter int MAX_OUTSTANDING = FETCH_OUTSTANDING
) (
   input  logic       aclk,
   input  logic       areset,
   input  logic       trap,
   input  word_t      handler,
   input  logic       branch,
   input  word_t      target,
   input  logic       bubble,
   output word_t      araddr,
   output logic       arvalid,
   input  logic       arready,
   output logic [2:0] arprot,
   input  word_t      rdata,
   input  logic       rvalid,
   output logic       rready,
   output id_t        tdata,
   output logic       tvalid,
   input  logic       tready
);

   localparam int CW = $clog2(DEPTH+1);
   localparam int OW = $clog2(MAX_OUTSTANDING+1);

   logic [OW-1:0] outstanding;
   logic [OW-1:0] outstanding_nx;
   logic [OW-1:0] discard;
   logic [OW-1:0] discard_nx;
   logic [CW-1:0] count;
   logic [CW:0]   occupancy;
   logic          empty;
   logic          full;
   logic          ar_hold;
   logic          redirect_pending;
   word_t         redirect_addr;
   word_t         rsp_pc;
   word_t         new_pc;
   id_t           head;
   logic          redirect;
   logic          ar_hs;
   logic          r_hs;
   logic          drop;
   logic          accept;
   logic          credit;
   logic          push;
   logic          pop;

   assign rready   = 1'b1;
   assign arprot   = AXI4;
   assign redirect = trap | branch;
   assign new_pc   = trap ? handler : target;
   assign ar_hs    = arvalid & arready;
   assign r_hs     = rvalid & rready;
   assign drop     = r_hs & (discard != '0);
   assign accept   = r_hs & ~drop & ~redirect;

   // Credit counts both queued entries and in-flight requests so that every
   // response always finds a free slot.
   assign occupancy = {1'b0, count} + (CW+1)'(outstanding);
   assign credit    = occupancy < (CW+1)'(DEPTH);

   // ar_hold keeps a started request asserted regardless of bubble/credit.
   assign arvalid = ~areset &
                    (ar_hold | (~bubble & (outstanding < OW'(MAX_OUTSTANDING)) & credit));

   assign outstanding_nx = outstanding + OW'(ar_hs) - OW'(r_hs);

`ifdef FETCH_QUEUE_BYPASS_EN
   logic bypass;
   assign bypass = empty & accept;
   assign tvalid = (~empty | bypass) & ~redirect;
   assign tdata  = empty ? {rsp_pc, rdata} : head;
   assign push   = accept & ~(bypass & tready) & ~full;
`else
   assign tvalid = ~empty & ~redirect;
   assign tdata  = head;
   assign push   = accept & ~full;
`endif

   assign pop = tvalid & tready & ~empty;

   // A redirect makes every request still in flight stale; a request that
   // carried the old address when a deferred redirect is applied is stale too.
   always_comb begin
      discard_nx = discard;
      if (redirect) discard_nx = outstanding_nx;
      else          discard_nx = discard - OW'(drop) + OW'(ar_hs & redirect_pending);
   end

   // Request address, deferred redirect and response bookkeeping.
   always_ff @(posedge aclk) begin
      if (areset) begin
         araddr           <= CODE_BASE;
         ar_hold          <= 1'b0;
         redirect_pending <= 1'b0;
         redirect_addr    <= CODE_BASE;
         outstanding      <= '0;
         discard          <= '0;
         rsp_pc           <= CODE_BASE;
      end else begin
         ar_hold     <= arvalid & ~arready;
         outstanding <= outstanding_nx;
         discard     <= discard_nx;

         if (redirect)    rsp_pc <= new_pc;
         else if (accept) rsp_pc <= rsp_pc + 32'd4;

         if (redirect) begin
            if (!arvalid || arready) begin
               araddr           <= new_pc;
               redirect_pending <= 1'b0;
            end else begin
               redirect_addr    <= new_pc;
               redirect_pending <= 1'b1;
            end
         end else if (ar_hs) begin
            if (redirect_pending) begin
               araddr           <= redirect_addr;
               redirect_pending <= 1'b0;
            end else begin
               araddr <= araddr + 32'd4;
            end
         end
      end
   end

   fetch_fifo #(
      .DEPTH (DEPTH)
   ) u_fifo (
      .aclk   (aclk),
      .areset (areset),
      .push   (push),
      .din    ({rsp_pc, rdata}),
      .pop    (pop),
      .flush  (redirect),
      .dout   (head),
      .count  (count),
      .empty  (empty),
      .full   (full)
   );

endmodule
